// File: rtl/uart_pkg.sv
// uart_pkg
//   Shared definitions for the UART receiver (and the matching transmitter):
//   receiver state encoding, parity-mode constants and the 3-tap majority
//   helper used by the line sampler.
//   No ports (package).
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_START      = 3'd1,
    ST_DATA       = 3'd2,
    ST_PARITY     = 3'd3,
    ST_STOP       = 3'd4,
    ST_BREAK_WAIT = 3'd5
  } rx_state_t;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  function automatic logic majority3(input logic [2:0] s);
    return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler
//   Brings the asynchronous RX line into the clock domain with a 2-flop
//   synchroniser, then keeps the last three synchronised samples and
//   reports their majority so a single-cycle glitch at mid-bit is ignored.
//   Ports:
//     i_Clock    in   system clock
//     i_Rst_L    in   synchronous reset, active low (everything resets to 1 = idle line)
//     rx_serial  in   raw asynchronous line
//     rx_sync    out  synchronised line (edge detection)
//     rx_vote    out  majority of the last three synchronised samples
module uart_rx_sampler
  import uart_pkg::*;
(
  input  logic i_Clock,
  input  logic i_Rst_L,
  input  logic rx_serial,
  output logic rx_sync,
  output logic rx_vote
);

  logic [1:0] sync_reg;
  logic [2:0] hist_reg;

  always_ff @(posedge i_Clock) begin
    if (!i_Rst_L) begin
      sync_reg <= 2'b11;
      hist_reg <= 3'b111;
    end else begin
      sync_reg <= {sync_reg[0], rx_serial};
      hist_reg <= {hist_reg[1:0], sync_reg[1]};
    end
  end

  assign rx_sync = sync_reg[1];
  assign rx_vote = majority3(hist_reg);

endmodule

// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg
//   Configurable UART receiver: DATA_BITS data bits LSB first, optional
//   odd/even parity, 1 or 2 stop bits. A completed frame is held in an
//   output register until the consumer takes it with i_RX_Ready; a frame
//   completing while the register is still full is dropped and flagged
//   with a one-cycle o_Overrun pulse.
//   Ports:
//     i_Clock      in   system clock
//     i_Rst_L      in   synchronous reset, active low
//     i_RX_Serial  in   asynchronous serial line, idle high
//     i_RX_Ready   in   consumer takes the held frame when o_RX_DV is high
//     o_RX_DV      out  frame held, high until accepted
//     o_RX_Byte    out  received data bits
//     o_Parity_Err out  parity mismatch on the held frame
//     o_Frame_Err  out  first stop bit sampled low on the held frame
//     o_Overrun    out  one-cycle pulse when a completed frame is dropped
//     o_Busy       out  receiver is not idle
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 217,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_MODE  = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 i_Clock,
  input  logic                 i_Rst_L,
  input  logic                 i_RX_Serial,
  input  logic                 i_RX_Ready,
  output logic                 o_RX_DV,
  output logic [DATA_BITS-1:0] o_RX_Byte,
  output logic                 o_Parity_Err,
  output logic                 o_Frame_Err,
  output logic                 o_Overrun,
  output logic                 o_Busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] MID       = CNT_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CNT_W-1:0] LAST      = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_BITS - 1);
  localparam logic             LAST_STOP = 1'(STOP_BITS - 1);
  localparam logic             ODD_SENSE = (PARITY_MODE == PARITY_ODD);

  logic rx_sync;
  logic rx_vote;

  uart_rx_sampler u_sampler (
    .i_Clock   (i_Clock),
    .i_Rst_L   (i_Rst_L),
    .rx_serial (i_RX_Serial),
    .rx_sync   (rx_sync),
    .rx_vote   (rx_vote)
  );

  rx_state_t            state_reg;
  logic [CNT_W-1:0]     cnt_reg;
  logic [IDX_W-1:0]     idx_reg;
  logic                 stop_idx_reg;
  logic [DATA_BITS-1:0] shift_reg;
  logic [DATA_BITS-1:0] shift_next;
  logic                 perr_reg;
  logic                 ferr_reg;
  logic                 dv_reg;
  logic [DATA_BITS-1:0] byte_reg;
  logic                 perr_out_reg;
  logic                 ferr_out_reg;
  logic                 ovr_reg;

  logic bit_end;
  logic frame_done;
  logic frame_ferr;

  // Only the bit addressed by idx_reg takes the voted sample.
  for (genvar gi = 0; gi < DATA_BITS; gi++) begin : g_shift
    assign shift_next[gi] = (idx_reg == IDX_W'(gi)) ? rx_vote : shift_reg[gi];
  end

  assign bit_end    = (cnt_reg == LAST);
  assign frame_done = (state_reg == ST_STOP) && bit_end && (stop_idx_reg == LAST_STOP);
  // With a single stop bit the framing verdict is formed in the completion
  // cycle itself, so it has to bypass ferr_reg.
  assign frame_ferr = (stop_idx_reg == 1'b0) ? ~rx_vote : ferr_reg;

  always_ff @(posedge i_Clock) begin
    if (!i_Rst_L) begin
      state_reg    <= ST_IDLE;
      cnt_reg      <= '0;
      idx_reg      <= '0;
      stop_idx_reg <= 1'b0;
      shift_reg    <= '0;
      perr_reg     <= 1'b0;
      ferr_reg     <= 1'b0;
      dv_reg       <= 1'b0;
      byte_reg     <= '0;
      perr_out_reg <= 1'b0;
      ferr_out_reg <= 1'b0;
      ovr_reg      <= 1'b0;
    end else begin
      ovr_reg <= 1'b0;

      case (state_reg)
        ST_IDLE: begin
          cnt_reg <= '0;
          if (!rx_sync) state_reg <= ST_START;
        end
        ST_START: begin
          if (cnt_reg == MID) begin
            cnt_reg   <= '0;
            idx_reg   <= '0;
            // A start bit that is high again at mid-bit was a glitch.
            state_reg <= rx_vote ? ST_IDLE : ST_DATA;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        ST_DATA: begin
          if (bit_end) begin
            cnt_reg   <= '0;
            shift_reg <= shift_next;
            if (idx_reg == LAST_IDX) begin
              stop_idx_reg <= 1'b0;
              state_reg    <= (PARITY_MODE != PARITY_NONE) ? ST_PARITY : ST_STOP;
            end else begin
              idx_reg <= idx_reg + IDX_W'(1);
            end
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        ST_PARITY: begin
          if (bit_end) begin
            cnt_reg      <= '0;
            perr_reg     <= (^shift_reg) ^ rx_vote ^ ODD_SENSE;
            stop_idx_reg <= 1'b0;
            state_reg    <= ST_STOP;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        ST_STOP: begin
          if (bit_end) begin
            cnt_reg <= '0;
            if (stop_idx_reg == 1'b0) ferr_reg <= ~rx_vote;
            if (stop_idx_reg == LAST_STOP) begin
              // Line still low at the last stop bit: wait out the break.
              state_reg <= rx_vote ? ST_IDLE : ST_BREAK_WAIT;
            end else begin
              stop_idx_reg <= 1'b1;
            end
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        ST_BREAK_WAIT: begin
          if (rx_sync) state_reg <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase

      // Output holding register: a completing frame wins over a plain accept
      // because it refills the register in the same cycle.
      if (frame_done) begin
        if (!dv_reg || i_RX_Ready) begin
          byte_reg     <= shift_reg;
          perr_out_reg <= (PARITY_MODE != PARITY_NONE) && perr_reg;
          ferr_out_reg <= frame_ferr;
          dv_reg       <= 1'b1;
        end else begin
          ovr_reg <= 1'b1;
        end
      end else if (dv_reg && i_RX_Ready) begin
        dv_reg <= 1'b0;
      end
    end
  end

  assign o_RX_DV      = dv_reg;
  assign o_RX_Byte    = byte_reg;
  assign o_Parity_Err = perr_out_reg;
  assign o_Frame_Err  = ferr_out_reg;
  assign o_Overrun    = ovr_reg;
  assign o_Busy       = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb_uart_rx_cfg
//   Three receiver instances (8N1, 7E1, 8O2) at 16 clocks per bit. Frames
//   are built bit by bit from the serial format rules; a negedge monitor
//   collects every accepted frame and the expectations come from the bits
//   that were put on the line.
module tb_uart_rx_cfg;

  localparam int CPB = 16;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] rx_l  = 3'b111;
  logic [2:0] rdy   = 3'b111;
  logic [2:0] dv, perr, ferr, ovr, busy;
  logic [7:0] byt_8n1;
  logic [6:0] byt_7e1;
  logic [7:0] byt_8o2;
  logic [8:0] byt [3];

  assign byt[0] = {1'b0, byt_8n1};
  assign byt[1] = {2'b00, byt_7e1};
  assign byt[2] = {1'b0, byt_8o2};

  // Per-instance frame format: data bits, parity mode (0 none/1 odd/2 even), stop bits.
  int nb[3] = '{8, 7, 8};
  int pm[3] = '{0, 2, 1};
  int ns[3] = '{1, 1, 2};

  always #5 clk = ~clk;

  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1)) u_8n1 (
    .i_Clock(clk), .i_Rst_L(rst_n), .i_RX_Serial(rx_l[0]), .i_RX_Ready(rdy[0]),
    .o_RX_DV(dv[0]), .o_RX_Byte(byt_8n1), .o_Parity_Err(perr[0]), .o_Frame_Err(ferr[0]),
    .o_Overrun(ovr[0]), .o_Busy(busy[0]));

  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY_MODE(2), .STOP_BITS(1)) u_7e1 (
    .i_Clock(clk), .i_Rst_L(rst_n), .i_RX_Serial(rx_l[1]), .i_RX_Ready(rdy[1]),
    .o_RX_DV(dv[1]), .o_RX_Byte(byt_7e1), .o_Parity_Err(perr[1]), .o_Frame_Err(ferr[1]),
    .o_Overrun(ovr[1]), .o_Busy(busy[1]));

  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(2)) u_8o2 (
    .i_Clock(clk), .i_Rst_L(rst_n), .i_RX_Serial(rx_l[2]), .i_RX_Ready(rdy[2]),
    .o_RX_DV(dv[2]), .o_RX_Byte(byt_8o2), .o_Parity_Err(perr[2]), .o_Frame_Err(ferr[2]),
    .o_Overrun(ovr[2]), .o_Busy(busy[2]));

  typedef struct {
    logic [8:0] b;
    logic       p;
    logic       f;
  } cap_t;

  cap_t capq[3][$];
  int   dv_cnt[3];
  int   ovr_cnt[3];
  int   n_pass  = 0;
  int   n_total = 0;

  // Monitor: a frame is taken at the next edge when DV and Ready are both high.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst_n && dv[i] && rdy[i]) capq[i].push_back('{byt[i], perr[i], ferr[i]});
      if (dv[i]) dv_cnt[i]++;
      if (ovr[i]) ovr_cnt[i]++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // All drive tasks start and end 1 time unit after a rising edge.
  task automatic drive_bit(input int sel, input logic b);
    rx_l[sel] = b;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic idle_bits(input int sel, input int n);
    repeat (n) drive_bit(sel, 1'b1);
  endtask

  task automatic send_frame(input int sel, input logic [8:0] data,
                            input logic par_bad, input logic stop0);
    int ones;
    logic p;
    logic [8:0] mask;
    mask = 9'((1 << nb[sel]) - 1);
    drive_bit(sel, 1'b0);
    for (int k = 0; k < nb[sel]; k++) drive_bit(sel, data[k]);
    if (pm[sel] != 0) begin
      ones = $countones(data & mask);
      // Even: parity bit makes the total count of ones even; odd: makes it odd.
      p = (pm[sel] == 2) ? (ones % 2 == 1) : (ones % 2 == 0);
      drive_bit(sel, p ^ par_bad);
    end
    drive_bit(sel, ~stop0);
    if (ns[sel] == 2) drive_bit(sel, 1'b1);
  endtask

  task automatic expect_frame(input int sel, input string name, input logic [8:0] eb,
                              input logic ep, input logic ef);
    cap_t c;
    c.b = 'x;
    c.p = 'x;
    c.f = 'x;
    chk({name, " frames"}, 32'(capq[sel].size()), 32'd1);
    if (capq[sel].size() > 0) c = capq[sel].pop_front();
    chk({name, " byte"}, 32'(c.b), 32'(eb));
    chk({name, " parity_err"}, 32'(c.p), 32'(ep));
    chk({name, " frame_err"}, 32'(c.f), 32'(ef));
    capq[sel].delete();
  endtask

  task automatic wait_idle(input int sel, input int max_clks, output logic ok);
    ok = 1'b0;
    for (int w = 0; w < max_clks && !ok; w++) begin
      @(negedge clk);
      if (!busy[sel]) ok = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    int         sel;
    logic [8:0] data;
    logic       par_bad;
    logic       stop0;
    logic [8:0] eb;
    logic       ep;
    logic       ef;
  } vec_t;

  vec_t vt[7];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int   s, d0, o0;
    logic ok;
    logic [7:0] bd;
    logic [8:0] rdat, rmask;
    logic rpb, rs0;

    vt[0] = '{0, 9'h0A5, 1'b0, 1'b0, 9'h0A5, 1'b0, 1'b0};
    vt[1] = '{1, 9'h055, 1'b1, 1'b0, 9'h055, 1'b1, 1'b0};
    vt[2] = '{1, 9'h055, 1'b0, 1'b0, 9'h055, 1'b0, 1'b0};
    vt[3] = '{2, 9'h09A, 1'b0, 1'b0, 9'h09A, 1'b0, 1'b0};
    vt[4] = '{2, 9'h03F, 1'b0, 1'b1, 9'h03F, 1'b0, 1'b1};
    vt[5] = '{0, 9'h000, 1'b0, 1'b0, 9'h000, 1'b0, 1'b0};
    vt[6] = '{1, 9'h07F, 1'b0, 1'b0, 9'h07F, 1'b0, 1'b0};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("reset dv", 32'(dv), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset flags", 32'({perr, ferr, ovr}), 32'd0);
    chk("reset byte 8n1", 32'(byt[0]), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle_bits(0, 1);

    // Table-driven frames, consumer always ready
    for (int i = 0; i < 7; i++) begin
      s  = vt[i].sel;
      d0 = dv_cnt[s];
      send_frame(s, vt[i].data, vt[i].par_bad, vt[i].stop0);
      idle_bits(s, 2);
      expect_frame(s, $sformatf("vec%0d", i), vt[i].eb, vt[i].ep, vt[i].ef);
      chk($sformatf("vec%0d dv cycles", i), 32'(dv_cnt[s] - d0), 32'd1);
    end

    // Break: 0x3C with a low stop bit, line held low for 40 bit times
    d0 = dv_cnt[0];
    bd = 8'h3C;
    drive_bit(0, 1'b0);
    for (int k = 0; k < 8; k++) drive_bit(0, bd[k]);
    repeat (40) drive_bit(0, 1'b0);
    @(negedge clk);
    chk("break busy held", 32'(busy[0]), 32'd1);
    @(posedge clk);
    #1;
    rx_l[0] = 1'b1;
    wait_idle(0, 8, ok);
    chk("break busy release", 32'(ok), 32'd1);
    idle_bits(0, 2);
    expect_frame(0, "break", 9'h03C, 1'b0, 1'b1);
    chk("break dv cycles", 32'(dv_cnt[0] - d0), 32'd1);

    // Glitch: line low for 3 clocks only
    d0 = dv_cnt[0];
    rx_l[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rx_l[0] = 1'b1;
    @(negedge clk);
    chk("glitch busy", 32'(busy[0]), 32'd1);
    @(posedge clk);
    #1;
    wait_idle(0, 10, ok);
    chk("glitch busy falls", 32'(ok), 32'd1);
    idle_bits(0, 12);
    chk("glitch no dv", 32'(dv_cnt[0] - d0), 32'd0);
    chk("glitch no frame", 32'(capq[0].size()), 32'd0);

    // Overrun: consumer stalled across two frames
    rdy[0] = 1'b0;
    o0 = ovr_cnt[0];
    send_frame(0, 9'h011, 1'b0, 1'b0);
    idle_bits(0, 2);
    send_frame(0, 9'h022, 1'b0, 1'b0);
    idle_bits(0, 2);
    @(negedge clk);
    chk("overrun dv held", 32'(dv[0]), 32'd1);
    chk("overrun byte kept", 32'(byt[0]), 32'h11);
    chk("overrun pulse cycles", 32'(ovr_cnt[0] - o0), 32'd1);
    @(posedge clk);
    #1;
    rdy[0] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("overrun dv drop", 32'(dv[0]), 32'd0);
    chk("overrun byte after accept", 32'(byt[0]), 32'h11);
    @(posedge clk);
    #1;
    expect_frame(0, "overrun", 9'h011, 1'b0, 1'b0);

    // Randomized frames against the format model
    for (int r = 0; r < 30; r++) begin
      s     = int'($urandom_range(0, 2));
      rmask = 9'((1 << nb[s]) - 1);
      rdat  = 9'($urandom) & rmask;
      rpb   = (pm[s] != 0) && ($urandom_range(0, 3) == 0);
      rs0   = ($urandom_range(0, 4) == 0);
      send_frame(s, rdat, rpb, rs0);
      idle_bits(s, 2);
      expect_frame(s, $sformatf("rand%0d", r), rdat, rpb, rs0);
    end

    // Reset in the middle of a frame on 8O2, with a frame already held
    rdy[2] = 1'b0;
    capq[2].delete();
    send_frame(2, 9'h05C, 1'b0, 1'b0);
    idle_bits(2, 2);
    @(negedge clk);
    chk("pre-reset dv", 32'(dv[2]), 32'd1);
    @(posedge clk);
    #1;
    drive_bit(2, 1'b0);
    drive_bit(2, 1'b1);
    drive_bit(2, 1'b0);
    drive_bit(2, 1'b1);
    rx_l[2] = 1'b1;
    rst_n   = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("mid-frame reset dv", 32'(dv[2]), 32'd0);
    chk("mid-frame reset busy", 32'(busy[2]), 32'd0);
    chk("mid-frame reset byte", 32'(byt[2]), 32'd0);
    chk("mid-frame reset flags", 32'({perr[2], ferr[2], ovr[2]}), 32'd0);
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    rdy[2] = 1'b1;
    idle_bits(2, 2);
    send_frame(2, 9'h09A, 1'b0, 1'b0);
    idle_bits(2, 2);
    expect_frame(2, "8O2 after reset", 9'h09A, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
